// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sequencer
// Description : Steps a 3-input DUT through all 8 input vectors in binary
//               order, holding each for DWELL cycles. The DUT output is
//               sampled at the last edge of each dwell into an 8-bit truth
//               table, which is compared with an expected table latched at
//               sweep start.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int DWELL = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       y,
    input  logic [7:0] expected,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] captured,
    output logic       pass
);

    localparam int              c_TIMER_W    = $clog2(DWELL + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_index;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [2:0]             r_vec;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_captured;
    logic                   r_pass;
    logic [7:0]             r_expected;

    // Final truth table as it will look once the current sample is written;
    // only meaningful on the last sample edge of the sweep (index 7).
    logic [7:0]             w_final_table;
    assign w_final_table = {y, r_captured[6:0]};

    // Sweep sequencer: vector stepping, dwell timing, sampling and verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_index    <= 3'd0;
            r_timer    <= '0;
            r_vec      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_captured <= 8'h00;
            r_pass     <= 1'b0;
            r_expected <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE holds its results until a new start is accepted.
                    if (start) begin
                        r_state    <= S_RUN;
                        r_index    <= 3'd0;
                        r_timer    <= '0;
                        r_vec      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_captured <= 8'h00;
                        r_expected <= expected;
                    end
                end

                S_RUN: begin
                    // start is deliberately ignored while a sweep is running.
                    if (r_timer != c_TIMER_LAST) begin
                        r_timer <= r_timer + 1'b1;
                    end else begin
                        r_timer             <= '0;
                        r_captured[r_index] <= y;
                        if (r_index != 3'd7) begin
                            r_index <= r_index + 3'd1;
                            r_vec   <= r_index + 3'd1;
                        end else begin
                            r_state <= S_DONE;
                            r_vec   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_final_table == r_expected);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_vec   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign a        = r_vec[2];
    assign b        = r_vec[1];
    assign c        = r_vec[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign captured = r_captured;
    assign pass     = r_pass;

endmodule
`default_nettype wire
